// File: rtl/mul_issue.sv
// Issue/writeback sequencer for RV32M multiply ops.
// Holds one op in flight and owns the handshake with an external multiplier.
module mul_issue #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        mul_start,
    output logic [31:0] mul_rs1,
    output logic [31:0] mul_rs2,
    output logic [2:0]  mul_funct3,
    input  logic [31:0] mul_result,
    input  logic        mul_done,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        WB,
        DRAIN
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       accept;
    logic       expired;

    assign in_ready = !flush && (state == IDLE || (state == WB && wb_ready));
    assign accept   = in_valid && in_ready;
    // >= so a count carried from WAIT into DRAIN still terminates
    assign expired  = (cnt >= 8'(TIMEOUT - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mul_start  <= 1'b0;
            mul_rs1    <= '0;
            mul_rs2    <= '0;
            mul_funct3 <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_err     <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            if (accept) begin
                mul_rs1    <= in_rs1;
                mul_rs2    <= in_rs2;
                mul_funct3 <= in_funct3;
                wb_rd      <= in_rd;
                wb_data    <= '0;
                wb_err     <= in_funct3[2];
                cnt        <= '0;
                if (in_funct3[2]) begin
                    state    <= WB;
                    wb_valid <= 1'b1;
                end else begin
                    state     <= START;
                    mul_start <= 1'b1;
                    wb_valid  <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: ;
                    // mul_done here is stale from the previous op
                    START: begin
                        cnt   <= '0;
                        state <= flush ? DRAIN : WAIT;
                    end
                    WAIT: begin
                        if (flush) begin
                            state <= DRAIN;
                            cnt   <= cnt + 8'd1;
                        end else if (mul_done) begin
                            state    <= WB;
                            wb_valid <= 1'b1;
                            wb_data  <= mul_result;
                            wb_err   <= 1'b0;
                        end else if (expired) begin
                            state    <= WB;
                            wb_valid <= 1'b1;
                            wb_data  <= '0;
                            wb_err   <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    WB: begin
                        if (flush || wb_ready) begin
                            state    <= IDLE;
                            wb_valid <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        if (mul_done || expired) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue with a 3-cycle sticky-done multiplier model.
module tb_mul_issue;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        flush;
    logic        mul_start;
    logic [31:0] mul_rs1;
    logic [31:0] mul_rs2;
    logic [2:0]  mul_funct3;
    logic [31:0] mul_result;
    logic        mul_done;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic        busy;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_start = 0;
    int s0;

    logic        stub;
    logic [1:0]  m_cnt;
    logic        m_done;
    logic [31:0] m_res;

    always #5 clk = ~clk;

    mul_issue #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_rd      (in_rd),
        .flush      (flush),
        .mul_start  (mul_start),
        .mul_rs1    (mul_rs1),
        .mul_rs2    (mul_rs2),
        .mul_funct3 (mul_funct3),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_err     (wb_err),
        .busy       (busy)
    );

    function automatic logic [31:0] mulfn(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [2:0] f);
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        xa = {{32{a[31] && f[1:0] != 2'd3}}, a};
        xb = {{32{b[31] && f[1:0] == 2'd1}}, b};
        p  = xa * xb;
        return (f[1:0] == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_done <= 1'b0;
            m_cnt  <= '0;
            m_res  <= '0;
        end else if (mul_start) begin
            m_done <= 1'b0;
            m_cnt  <= 2'd2;
            m_res  <= mulfn(mul_rs1, mul_rs2, mul_funct3);
        end else if (m_cnt != 2'd0) begin
            m_cnt <= m_cnt - 2'd1;
            if (m_cnt == 2'd1 && !stub) m_done <= 1'b1;
        end
    end

    assign mul_done   = m_done;
    assign mul_result = m_res;

    always @(negedge clk) if (mul_start) n_start++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [4:0] rd);
        in_valid  = 1'b1;
        in_rs1    = a;
        in_rs2    = b;
        in_funct3 = f;
        in_rd     = rd;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic expect_wb(input string tag, input int lat,
                             input logic [4:0] rd, input logic [31:0] data,
                             input logic err);
        int k;
        k = 1;
        while (!wb_valid && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'(lat));
        chk({tag, "_rd"}, 64'(wb_rd), 64'(rd));
        chk({tag, "_data"}, 64'(wb_data), 64'(data));
        chk({tag, "_err"}, 64'(wb_err), 64'(err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_rd     = '0;
        flush     = 1'b0;
        wb_ready  = 1'b1;
        stub      = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_wbv", 64'(wb_valid), 0);
        chk("rst_start", 64'(mul_start), 0);
        chk("rst_data", 64'(wb_data), 0);
        reset = 1'b1;
        tick();
        chk("rst_ready", 64'(in_ready), 1);

        // MUL 7 * -3
        s0 = n_start;
        issue(32'd7, 32'hFFFF_FFFD, 3'b000, 5'd5);
        chk("mul_start", 64'(mul_start), 1);
        chk("mul_busy", 64'(busy), 1);
        chk("mul_noready", 64'(in_ready), 0);
        chk("mul_rs2", 64'(mul_rs2), 64'h0000_0000_FFFF_FFFD);
        expect_wb("mul", 5, 5'd5, 32'hFFFF_FFEB, 1'b0);
        chk("mul_nstart", 64'(n_start - s0), 1);
        tick();
        chk("mul_idle_wbv", 64'(wb_valid), 0);
        chk("mul_idle_busy", 64'(busy), 0);

        // MULHU with stale done still high from the previous op
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 5'd6);
        chk("mulhu_f3", 64'(mul_funct3), 3);
        expect_wb("mulhu", 5, 5'd6, 32'hFFFF_FFFE, 1'b0);
        tick();

        // unsupported funct3
        s0 = n_start;
        issue(32'd1, 32'd2, 3'b100, 5'd8);
        expect_wb("unsup", 1, 5'd8, 32'd0, 1'b1);
        tick();
        chk("unsup_nstart", 64'(n_start - s0), 0);
        chk("unsup_busy", 64'(busy), 0);

        // writeback backpressure, then back-to-back accept
        wb_ready = 1'b0;
        issue(32'd3, 32'd5, 3'b000, 5'd9);
        expect_wb("bp", 5, 5'd9, 32'd15, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_wbv", 64'(wb_valid), 1);
            chk("bp_rd", 64'(wb_rd), 9);
            chk("bp_data", 64'(wb_data), 15);
            chk("bp_noready", 64'(in_ready), 0);
        end
        wb_ready  = 1'b1;
        in_valid  = 1'b1;
        in_rs1    = 32'h8000_0000;
        in_rs2    = 32'd2;
        in_funct3 = 3'b001;
        in_rd     = 5'd3;
        #0;
        chk("b2b_ready", 64'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("b2b_start", 64'(mul_start), 1);
        chk("b2b_wbv", 64'(wb_valid), 0);
        chk("b2b_f3", 64'(mul_funct3), 1);
        expect_wb("b2b", 5, 5'd3, 32'hFFFF_FFFF, 1'b0);
        tick();

        // MULHSU -2 * 2^31
        issue(32'hFFFF_FFFE, 32'h8000_0000, 3'b010, 5'd10);
        chk("mulhsu_f3", 64'(mul_funct3), 2);
        expect_wb("mulhsu", 5, 5'd10, 32'hFFFF_FFFF, 1'b0);
        tick();

        // flush in IDLE blocks acceptance
        in_valid  = 1'b1;
        flush     = 1'b1;
        in_funct3 = 3'b000;
        #0;
        chk("fidle_ready", 64'(in_ready), 0);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("fidle_busy", 64'(busy), 0);
        chk("fidle_start", 64'(mul_start), 0);

        // flush in WAIT drains without writeback
        issue(32'd2, 32'd2, 3'b000, 5'd7);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fwait_busy3", 64'(busy), 1);
        chk("fwait_ready3", 64'(in_ready), 0);
        chk("fwait_wbv3", 64'(wb_valid), 0);
        tick();
        chk("fwait_busy4", 64'(busy), 1);
        tick();
        chk("fwait_busy5", 64'(busy), 0);
        for (int i = 0; i < 2; i++) begin
            chk("fwait_wbv", 64'(wb_valid), 0);
            tick();
        end

        // flush in WB wins over wb_ready
        wb_ready = 1'b0;
        issue(32'd1, 32'd1, 3'b000, 5'd4);
        expect_wb("wbf", 5, 5'd4, 32'd1, 1'b0);
        flush    = 1'b1;
        wb_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("wbf_wbv", 64'(wb_valid), 0);
        chk("wbf_busy", 64'(busy), 0);

        // stubbed multiplier times out after TIMEOUT WAIT cycles
        stub = 1'b1;
        issue(32'd5, 32'd5, 3'b000, 5'd11);
        expect_wb("tmo", 2 + TIMEOUT, 5'd11, 32'd0, 1'b1);
        tick();
        stub = 1'b0;
        chk("tmo_busy", 64'(busy), 0);

        // asynchronous reset mid-WAIT
        issue(32'd4, 32'd4, 3'b011, 5'd12);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 0);
        chk("arst_rs1", 64'(mul_rs1), 0);
        chk("arst_rs2", 64'(mul_rs2), 0);
        chk("arst_f3", 64'(mul_funct3), 0);
        chk("arst_rd", 64'(wb_rd), 0);
        chk("arst_wbv", 64'(wb_valid), 0);
        chk("arst_start", 64'(mul_start), 0);
        chk("arst_data", 64'(wb_data), 0);
        chk("arst_err", 64'(wb_err), 0);
        #1;
        reset = 1'b1;
        tick();
        chk("arst_ready", 64'(in_ready), 1);
        issue(32'd6, 32'd7, 3'b000, 5'd1);
        expect_wb("post", 5, 5'd1, 32'd42, 1'b0);
        tick();
        chk("post_busy", 64'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 Parameter TIMEOUT, default 8: cycles in WAIT without mul_done before the op is aborted with an error (legal 4..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 in_valid  input  1  decode stage presents an M-extension op.
REQ-005 in_ready  output  1  block accepts op this cycle.
REQ-006 in_rs1, in_rs2  input  32 each  source operands.
REQ-007 in_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx unsupported.
REQ-008 in_rd  input  5  destination register index.
REQ-009 flush  input  1  pipeline flush; kill in-flight op.
REQ-010 mul_start  output  1  one-cycle start pulse to multiplier.
REQ-011 mul_rs1, mul_rs2  output  32 each  latched operands to multiplier.
REQ-012 mul_funct3  output  3  latched funct3 to multiplier.
REQ-013 mul_result  input  32  multiplier result.
REQ-014 mul_done  input  1  multiplier completion (sticky: stays 1 until the multiplier samples the next start).
REQ-015 wb_valid  output  1  writeback result available.
REQ-016 wb_ready  input  1  register file accepts writeback.
REQ-017 wb_rd  output  5  destination index; wb_data  output  32  result; wb_err  output  1  op aborted.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, START, WAIT, WB, DRAIN; encoding is free.
REQ-020 in_ready = 1 in IDLE, or in WB when wb_ready=1; 0 otherwise; forced 0 when flush=1.
REQ-021 Accept (in_valid & in_ready & !flush): latch rs1, rs2, funct3, rd; clear wb_err; go to START if funct3[2]=0; if funct3[2]=1 go directly to WB with wb_data=0, wb_err=1, and no mul_start.
REQ-022 START: mul_start=1 for exactly one cycle; next state WAIT (DRAIN if flush=1 this cycle); the start pulse is never suppressed once START is entered.
REQ-023 mul_rs1/mul_rs2/mul_funct3 hold latched values from acceptance until the next acceptance; they never change while in START, WAIT or DRAIN.
REQ-024 mul_done is ignored in IDLE and START (stale sticky value); it is sampled only in WAIT and DRAIN.
REQ-025 WAIT: 8-bit timeout counter cleared on entry, +1 per cycle; on mul_done=1 capture wb_data=mul_result, wb_err=0, go to WB.
REQ-026 WAIT: if counter reaches TIMEOUT with mul_done=0, go to WB with wb_data=0, wb_err=1.
REQ-027 WAIT with flush=1 goes to DRAIN regardless of mul_done; DRAIN waits for mul_done (or TIMEOUT) then goes to IDLE with no wb_valid.
REQ-028 WB: wb_valid=1; wb_rd/wb_data/wb_err stable until wb_ready=1; on wb_ready go to IDLE, or to START/WB if a new op is accepted in the same cycle (back-to-back).
REQ-029 WB with flush=1: drop result, wb_valid=0 from next cycle, go to IDLE; flush has priority over wb_ready.
REQ-030 IDLE with flush=1 and in_valid=1: op not accepted.
REQ-031 rd=0 ops execute and write back normally; the register file discards them.
REQ-032 Latency: acceptance at cycle T -> mul_start at T+1 -> wb_valid at T+5 for a 3-cycle multiplier; unsupported funct3 -> wb_valid at T+1.
REQ-033 Throughput: one op in flight; a new mul_start never issues before the previous op leaves WAIT/DRAIN.

Reset
REQ-034 reset=0 asynchronously forces IDLE, timeout counter 0, and mul_start, wb_valid, wb_err, busy, mul_rs1, mul_rs2, mul_funct3, wb_rd and wb_data all 0; in_ready=1 once reset=1.
REQ-035 Reset mid-operation discards the op with no writeback; because the multiplier may still be busy, it shall be reset in the same cycle.

Verification
REQ-036 MUL rs1=7, rs2=-3, rd=5, wb_ready=1 -> one mul_start at T+1; wb_valid at T+5 with wb_rd=5, wb_data=0xFFFFFFEB, wb_err=0.
REQ-037 MULHU rs1=rs2=0xFFFFFFFF with stale mul_done=1 at acceptance -> done ignored in START; wb_data=0xFFFFFFFE at T+5.
REQ-038 funct3=100 -> no mul_start; wb_valid at T+1 with wb_err=1, wb_data=0.
REQ-039 wb_ready held 0 for 4 cycles -> wb_valid, wb_rd and wb_data stable; with in_valid=1 when wb_ready rises -> back-to-back accept and mul_start the next cycle.
REQ-040 flush in WAIT -> DRAIN, no wb_valid, busy until mul_done; mul_done held 0 (stubbed multiplier) -> wb_err=1 after TIMEOUT=8 WAIT cycles.
REQ-041 reset=0 asserted mid-WAIT -> all outputs 0 immediately (asynchronously); after release a fresh MUL completes correctly.
